// File: rtl/prefetch_ctrl.sv
// prefetch_ctrl: instruction prefetch sequencer between the instruction-memory
// port and the fetch FIFO. Issues word-aligned requests, caps outstanding
// requests, tags each response with its fetch address and flushes on redirect.
module prefetch_ctrl #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h1000_0000,
    parameter int unsigned     MAX_OUTST = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            fifo_ready_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            fifo_valid_o,
    output logic [XLEN-1:0] fifo_addr_o,
    output logic [XLEN-1:0] fifo_instr_o,
    output logic            fifo_clear_o,
    output logic            busy_o
);

    localparam int unsigned     CW        = $clog2(MAX_OUTST + 1);
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

    state_e                         state_q, state_d;
    logic [XLEN-1:0]                fetch_pc_q;
    logic [XLEN-1:0]                first_tag_q;
    logic                           first_pend_q;
    logic [CW-1:0]                  outst_q, outst_d;
    logic [CW-1:0]                  discard_q;
    logic                           req_pend_q;
    logic [MAX_OUTST-1:0][XLEN-1:0] tagq_q;
    logic [CW-1:0]                  qcnt_q;
    logic [CW-1:0]                  widx;
    logic                           fifo_valid_q;
    logic [XLEN-1:0]                fifo_addr_q, fifo_instr_q;

    logic redir, rsp_vld, gnt_fire, fwd;

    // Redirects are ignored during the single BOOT cycle; responses with
    // nothing outstanding are protocol violations and are dropped.
    assign redir    = redirect_i && (state_q != BOOT);
    assign rsp_vld  = imem_rvalid_i && (outst_q != '0);
    assign gnt_fire = imem_req_o && imem_gnt_i;
    assign fwd      = rsp_vld && (state_q == RUN) && !redirect_i;
    assign outst_d  = outst_q + CW'(gnt_fire) - CW'(rsp_vld);
    assign widx     = qcnt_q - CW'(fwd);

    assign imem_addr_o  = fetch_pc_q;
    assign fifo_clear_o = redirect_i;
    assign fifo_valid_o = fifo_valid_q;
    assign fifo_addr_o  = fifo_addr_q;
    assign fifo_instr_o = fifo_instr_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= BOOT;
        else         state_q <= state_d;
    end

    // Next-state: redirect wins; FLUSH exits once the last stale response drops
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:  state_d = RUN;
            RUN:   if (redir) state_d = (outst_d != '0) ? FLUSH : RUN;
            FLUSH: begin
                if (redir)                                state_d = (outst_d != '0) ? FLUSH : RUN;
                else if (rsp_vld && discard_q == CW'(1)) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // Outputs: a raised request is held until granted; a redirect withdraws it
    always_comb begin
        imem_req_o = (state_q == RUN) && !redirect_i &&
                     (req_pend_q || (fifo_ready_i && (outst_q < CW'(MAX_OUTST))));
        busy_o     = (outst_q != '0) || (state_q == FLUSH);
    end

    // Fetch address, redirect tag bookkeeping and outstanding/discard counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q   <= RESET_PC & WORD_MASK;
            first_tag_q  <= RESET_PC;
            first_pend_q <= 1'b1;
            outst_q      <= '0;
            discard_q    <= '0;
            req_pend_q   <= 1'b0;
        end else begin
            outst_q    <= outst_d;
            req_pend_q <= imem_req_o && !imem_gnt_i;
            if (redir) begin
                fetch_pc_q   <= redirect_pc_i & WORD_MASK;
                first_tag_q  <= redirect_pc_i;
                first_pend_q <= 1'b1;
                discard_q    <= outst_d;
            end else begin
                if (gnt_fire)                    fetch_pc_q   <= fetch_pc_q + XLEN'(4);
                if (fwd)                         first_pend_q <= 1'b0;
                if (state_q == FLUSH && rsp_vld) discard_q    <= discard_q - CW'(1);
            end
        end
    end

    // Tag queue: shift-out at entry 0 on pop, write at the tail on push
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tagq_q <= '0;
            qcnt_q <= '0;
        end else if (redir) begin
            qcnt_q <= '0;
        end else begin
            qcnt_q <= qcnt_q + CW'(gnt_fire) - CW'(fwd);
            for (int i = 0; i < MAX_OUTST; i++) begin
                if (gnt_fire && CW'(i) == widx)
                    tagq_q[i] <= fetch_pc_q;
                else if (fwd && i < MAX_OUTST - 1)
                    tagq_q[i] <= tagq_q[(i + 1) % MAX_OUTST];
            end
        end
    end

    // Registered FIFO push; first word after reset/redirect carries the exact PC
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_valid_q <= 1'b0;
            fifo_addr_q  <= '0;
            fifo_instr_q <= '0;
        end else begin
            fifo_valid_q <= fwd;
            if (fwd) begin
                fifo_addr_q  <= first_pend_q ? first_tag_q : tagq_q[0];
                fifo_instr_q <= imem_rdata_i;
            end
        end
    end

endmodule
